// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit with AXI4-Lite master.
//   - lsu_state_e : controller FSM states
//   - lsu_size_e  : request access size encoding (byte/half/word/dword)
//   - AXI_*       : AXI response codes
//   - size_strb   : byte-lane mask for an access size (LSB-aligned)
//   - load_extend : sign/zero extension of LSB-aligned load data
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPM,
    ST_AXW,
    ST_AXB,
    ST_AXR_A,
    ST_AXR_D,
    ST_RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } lsu_size_e;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  function automatic logic [7:0] size_strb(input lsu_size_e size);
    logic [7:0] m;
    case (size)
      SZ_BYTE: m = 8'h01;
      SZ_HALF: m = 8'h03;
      SZ_WORD: m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Extends from bit 8*2^size-1; uns forces zero extension.
  function automatic logic [63:0] load_extend(input logic [63:0] d,
                                              input lsu_size_e size,
                                              input logic uns);
    logic [63:0] r;
    case (size)
      SZ_BYTE: r = {{56{~uns & d[7]}},  d[7:0]};
      SZ_HALF: r = {{48{~uns & d[15]}}, d[15:0]};
      SZ_WORD: r = {{32{~uns & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_axil_ctrl_spm.sv
// Local scratchpad: one synchronous port, SPM_WORDS x DATA_W, byte-write
// enables. When en is high the addressed word is read (old contents) and the
// enabled byte lanes are written in the same cycle. Contents are not reset.
// Ports:
//   clk   : clock
//   en    : access enable
//   we    : byte-lane write enables (DATA_W/8)
//   idx   : word index
//   wdata : lane-aligned write data
//   rdata : registered read data
module lsu_spm
  import lsu_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int SPM_WORDS = 256,
  localparam int NB       = DATA_W / 8,
  localparam int IDX_W    = $clog2(SPM_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [NB-1:0]     we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [SPM_WORDS];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem_q[idx];
      for (int b = 0; b < NB; b++) begin
        if (we[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lsu_axil_ctrl.sv
// Load/store unit controller. Accepts one request at a time, serves it from
// the local scratchpad when the address falls in the SPM window, otherwise
// issues a single AXI4-Lite read or write. Misaligned requests complete with
// an error without touching the scratchpad or the bus.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   req_valid/req_ready            : request handshake (ready only when idle)
//   req_wen, req_addr, req_wdata   : store enable, byte address, LSB-aligned data
//   req_size, req_unsigned         : access size, zero-extend loads
//   resp_valid/resp_rdata/resp_err : one-cycle response
//   aw*/w*/b*/ar*/r*               : AXI4-Lite master channels
module lsu_axil_ctrl
  import lsu_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] SPM_BASE  = 32'h8000_0000,
  parameter int                SPM_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(SPM_WORDS);
  localparam logic [ADDR_W-1:0] SPM_SPAN = ADDR_W'(SPM_WORDS * NB);

  lsu_state_e        state_q, state_d;
  logic              wen_q, wen_d;
  lsu_size_e         size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] lane_data_q, lane_data_d;
  logic [NB-1:0]     lane_strb_q, lane_strb_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              hold_q, hold_d;
  logic              spm_load_q, spm_load_d;

  // Request decode (combinational on the incoming request)
  lsu_size_e         req_sz;
  logic [2:0]        align_mask;
  logic              req_misaligned;
  logic [ADDR_W-1:0] req_spm_off;
  logic              req_in_spm;
  logic [OFF_W-1:0]  req_lane;
  logic [NB-1:0]     req_strb_base;
  logic [ADDR_W-1:0] req_aligned;

  logic [OFF_W-1:0]  lane_q;
  logic              spm_en;
  logic [NB-1:0]     spm_we;
  logic [IDX_W-1:0]  spm_idx;
  logic [DATA_W-1:0] spm_rdata;
  logic [DATA_W-1:0] spm_ext;

  always_comb begin
    req_sz = lsu_size_e'(req_size);
    case (req_sz)
      SZ_BYTE: align_mask = 3'b000;
      SZ_HALF: align_mask = 3'b001;
      SZ_WORD: align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    // A dword cannot be carried on a 32-bit data path.
    req_misaligned = ((req_addr[2:0] & align_mask) != 3'b000) ||
                     ((req_sz == SZ_DWORD) && (DATA_W == 32));
    req_spm_off    = req_addr - SPM_BASE;
    req_in_spm     = (req_addr >= SPM_BASE) && (req_spm_off < SPM_SPAN);
    req_lane       = req_addr[OFF_W-1:0];
    req_strb_base  = NB'(size_strb(req_sz));
    req_aligned    = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

  always_comb begin
    state_d     = state_q;
    wen_d       = wen_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    lane_data_d = lane_data_q;
    lane_strb_d = lane_strb_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    hold_d      = hold_q;
    spm_load_d  = spm_load_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wen_d       = req_wen;
          size_d      = req_sz;
          uns_d       = req_unsigned;
          addr_d      = req_addr;
          lane_data_d = req_wdata << {req_lane, 3'b000};
          lane_strb_d = req_strb_base << req_lane;
          err_d       = 1'b0;
          rdata_d     = '0;
          hold_d      = 1'b0;
          spm_load_d  = 1'b0;
          if (req_misaligned) begin
            // Extra RESP cycle keeps error latency equal to the SPM path.
            state_d = ST_RESP;
            err_d   = 1'b1;
            hold_d  = 1'b1;
          end else if (req_in_spm) begin
            state_d    = ST_SPM;
            spm_load_d = ~req_wen;
          end else if (req_wen) begin
            state_d   = ST_AXW;
            awaddr_d  = req_aligned;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_AXR_A;
            araddr_d  = req_aligned;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_SPM: state_d = ST_RESP;
      ST_AXW: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        // Each channel is done if it already completed or completes now.
        if ((!awvalid_q || awready) && (!wvalid_q || wready)) state_d = ST_AXB;
      end
      ST_AXB: begin
        if (bvalid) begin
          state_d = ST_RESP;
          err_d   = (bresp != AXI_OKAY);
          rdata_d = '0;
        end
      end
      ST_AXR_A: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_AXR_D;
        end
      end
      ST_AXR_D: begin
        if (rvalid) begin
          state_d = ST_RESP;
          err_d   = (rresp != AXI_OKAY);
          rdata_d = (rresp != AXI_OKAY) ? '0 :
                    DATA_W'(load_extend(64'(rdata >> {lane_q, 3'b000}), size_q, uns_q));
        end
      end
      ST_RESP: begin
        if (hold_q) begin
          hold_d = 1'b0;
        end else begin
          state_d    = ST_IDLE;
          spm_load_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      err_q       <= 1'b0;
      hold_q      <= 1'b0;
      spm_load_q  <= 1'b0;
      rdata_q     <= '0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      lane_data_q <= '0;
      lane_strb_q <= '0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      err_q       <= err_d;
      hold_q      <= hold_d;
      spm_load_q  <= spm_load_d;
      rdata_q     <= rdata_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      lane_data_q <= lane_data_d;
      lane_strb_q <= lane_strb_d;
    end
    wen_q  <= wen_d;
    size_q <= size_d;
    uns_q  <= uns_d;
    addr_q <= addr_d;
  end

  assign lane_q  = addr_q[OFF_W-1:0];
  assign spm_en  = (state_q == ST_SPM);
  assign spm_we  = wen_q ? lane_strb_q : '0;
  assign spm_idx = IDX_W'((addr_q - SPM_BASE) >> OFF_W);
  assign spm_ext = DATA_W'(load_extend(64'(spm_rdata >> {lane_q, 3'b000}), size_q, uns_q));

  lsu_spm #(
    .DATA_W    (DATA_W),
    .SPM_WORDS (SPM_WORDS)
  ) u_spm (
    .clk   (clk),
    .en    (spm_en),
    .we    (spm_we),
    .idx   (spm_idx),
    .wdata (lane_data_q),
    .rdata (spm_rdata)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP) && !hold_q;
  assign resp_rdata = !resp_valid ? '0 : (spm_load_q ? spm_ext : rdata_q);
  assign resp_err   = resp_valid && err_q;

  assign awaddr  = awaddr_q;
  assign awvalid = awvalid_q;
  assign wdata   = lane_data_q;
  assign wstrb   = lane_strb_q;
  assign wvalid  = wvalid_q;
  assign bready  = (state_q == ST_AXB);
  assign araddr  = araddr_q;
  assign arvalid = arvalid_q;
  assign rready  = (state_q == ST_AXR_D);

endmodule

// File: tb/tb_lsu_axil_ctrl.sv
module tb_lsu_axil_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;

  // Slave configuration (written by the stimulus only)
  int          cfg_aw_delay = 0, cfg_w_delay = 0, cfg_ar_delay = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic        cfg_r_hold = 1'b0;

  // Slave state and monitors (written by the slave process only)
  logic        got_aw = 0, got_w = 0, got_ar = 0, b_hs = 0, r_hs = 0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  logic [31:0] smem [int unsigned];
  int aw_vld_cyc = 0, w_vld_cyc = 0, ar_vld_cyc = 0;
  int aw_hs_cnt = 0, ar_hs_cnt = 0, b_hs_cnt = 0, resp_cnt = 0;

  always #5 clk = ~clk;

  lsu_axil_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // AXI4-Lite slave: samples handshakes on posedge, drives on negedge.
  initial begin
    logic [31:0] tmp;
    int unsigned key;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(posedge clk);
      if (awvalid) aw_vld_cyc++;
      if (wvalid) w_vld_cyc++;
      if (arvalid) ar_vld_cyc++;
      if (resp_valid) resp_cnt++;
      if (!rst) begin
        if (awvalid && awready) begin got_aw = 1; cap_awaddr = awaddr; aw_hs_cnt++; end
        if (wvalid && wready) begin got_w = 1; cap_wdata = wdata; cap_wstrb = wstrb; end
        if (bvalid && bready) begin b_hs = 1; b_hs_cnt++; end
        if (arvalid && arready) begin got_ar = 1; cap_araddr = araddr; ar_hs_cnt++; end
        if (rvalid && rready) r_hs = 1;
      end
      @(negedge clk);
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        got_aw = 0; got_w = 0; got_ar = 0; b_hs = 0; r_hs = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      end else begin
        if (awvalid) begin awready = (aw_cnt == cfg_aw_delay); aw_cnt++; end
        else begin awready = 0; aw_cnt = 0; end
        if (wvalid) begin wready = (w_cnt == cfg_w_delay); w_cnt++; end
        else begin wready = 0; w_cnt = 0; end
        if (arvalid) begin arready = (ar_cnt == cfg_ar_delay); ar_cnt++; end
        else begin arready = 0; ar_cnt = 0; end
        if (b_hs) begin bvalid = 0; b_hs = 0; end
        if (got_aw && got_w && !bvalid) begin
          key = cap_awaddr >> 2;
          tmp = smem.exists(key) ? smem[key] : 32'h0;
          for (int b = 0; b < 4; b++) if (cap_wstrb[b]) tmp[8*b +: 8] = cap_wdata[8*b +: 8];
          smem[key] = tmp;
          bvalid = 1; bresp = cfg_bresp; got_aw = 0; got_w = 0;
        end
        if (r_hs) begin rvalid = 0; r_hs = 0; end
        if (got_ar && !rvalid && !cfg_r_hold) begin
          key = cap_araddr >> 2;
          rdata = smem.exists(key) ? smem[key] : 32'h0;
          rresp = cfg_rresp; rvalid = 1; got_ar = 0;
        end
      end
    end
  end

  // Issues one request; afterwards scrambles req_* to show they are ignored.
  // lat counts cycles from the acceptance cycle to the resp_valid cycle.
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input logic un,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic extra);
    int n;
    logic done;
    rd = 0; er = 0; lat = -1; extra = 0; done = 0; n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd;
    req_size = sz; req_unsigned = un;
    @(posedge clk); #1;
    req_valid = 0; req_wen = ~wen; req_addr = ~addr; req_wdata = ~wd;
    req_size = ~sz; req_unsigned = ~un;
    for (int i = 1; i <= 60 && !done; i++) begin
      if (resp_valid) begin lat = i; rd = resp_rdata; er = resp_err; done = 1; end
      else begin @(posedge clk); #1; end
    end
    if (!done) begin total++; bad++; $display("FAIL req_timeout addr=%h", addr); end
    else begin @(posedge clk); #1; extra = resp_valid; end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
    total++; if ({awvalid, wvalid, arvalid, bready, rready, resp_valid, resp_err} !== 7'b0) begin bad++; $display("FAIL rst_ctrl got=%b want=0000000", {awvalid, wvalid, arvalid, bready, rready, resp_valid, resp_err}); end
    total++; if ({awaddr, araddr, wdata, wstrb, resp_rdata} !== 132'h0) begin bad++; $display("FAIL rst_data got=%h/%h/%h/%h/%h want=0", awaddr, araddr, wdata, wstrb, resp_rdata); end
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL post_rst_idle got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
  endtask

  task automatic test_spm();
    logic [31:0] rd; logic er, ex; int lat, aw0, ar0;
    aw0 = aw_hs_cnt; ar0 = ar_hs_cnt;
    do_req(1, 32'h8000_0010, 32'hDEAD_BEEF, 2'd2, 0, rd, er, lat, ex);
    total++; if (lat !== 2 || er !== 0 || rd !== 32'h0) begin bad++; $display("FAIL spm_sw got lat=%0d err=%b rd=%h want 2/0/0", lat, er, rd); end
    total++; if (ex !== 1'b0) begin bad++; $display("FAIL spm_resp_pulse got=%b want=0", ex); end
    do_req(0, 32'h8000_0010, 32'h0, 2'd2, 0, rd, er, lat, ex);
    total++; if (lat !== 2 || er !== 0 || rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL spm_lw got lat=%0d err=%b rd=%h want 2/0/deadbeef", lat, er, rd); end
    do_req(1, 32'h8000_0011, 32'h0000_0055, 2'd0, 0, rd, er, lat, ex);
    do_req(0, 32'h8000_0010, 32'h0, 2'd2, 0, rd, er, lat, ex);
    total++; if (rd !== 32'hDEAD_55EF) begin bad++; $display("FAIL spm_sb_merge got=%h want=dead55ef", rd); end
    do_req(0, 32'h8000_0012, 32'h0, 2'd1, 0, rd, er, lat, ex);
    total++; if (rd !== 32'hFFFF_DEAD) begin bad++; $display("FAIL spm_lh got=%h want=ffffdead", rd); end
    do_req(0, 32'h8000_0012, 32'h0, 2'd1, 1, rd, er, lat, ex);
    total++; if (rd !== 32'h0000_DEAD) begin bad++; $display("FAIL spm_lhu got=%h want=0000dead", rd); end
    do_req(1, 32'h8000_03FC, 32'hA5A5_0001, 2'd2, 0, rd, er, lat, ex);
    do_req(0, 32'h8000_03FC, 32'h0, 2'd2, 0, rd, er, lat, ex);
    total++; if (rd !== 32'hA5A5_0001 || lat !== 2) begin bad++; $display("FAIL spm_last_word got rd=%h lat=%0d want a5a50001/2", rd, lat); end
    total++; if (aw_hs_cnt - aw0 !== 0 || ar_hs_cnt - ar0 !== 0) begin bad++; $display("FAIL spm_no_bus got aw=%0d ar=%0d want 0/0", aw_hs_cnt - aw0, ar_hs_cnt - ar0); end
    do_req(0, 32'h8000_0400, 32'h0, 2'd2, 0, rd, er, lat, ex);
    total++; if (ar_hs_cnt - ar0 !== 1 || cap_araddr !== 32'h8000_0400) begin bad++; $display("FAIL spm_window_end got ar=%0d araddr=%h want 1/80000400", ar_hs_cnt - ar0, cap_araddr); end
  endtask

  task automatic test_bus_byte();
    logic [31:0] rd; logic er, ex; int lat;
    do_req(1, 32'h1000_0003, 32'h0000_0080, 2'd0, 0, rd, er, lat, ex);
    total++; if (cap_awaddr !== 32'h1000_0000) begin bad++; $display("FAIL sb_awaddr got=%h want=10000000", cap_awaddr); end
    total++; if (cap_wstrb !== 4'b1000) begin bad++; $display("FAIL sb_wstrb got=%b want=1000", cap_wstrb); end
    total++; if (cap_wdata !== 32'h8000_0000) begin bad++; $display("FAIL sb_wdata got=%h want=80000000", cap_wdata); end
    total++; if (er !== 0 || rd !== 32'h0) begin bad++; $display("FAIL sb_resp got err=%b rd=%h want 0/0", er, rd); end
    do_req(0, 32'h1000_0003, 32'h0, 2'd0, 0, rd, er, lat, ex);
    total++; if (rd !== 32'hFFFF_FF80 || er !== 0) begin bad++; $display("FAIL lb got rd=%h err=%b want ffffff80/0", rd, er); end
    total++; if (cap_araddr !== 32'h1000_0000) begin bad++; $display("FAIL lb_araddr got=%h want=10000000", cap_araddr); end
    do_req(0, 32'h1000_0003, 32'h0, 2'd0, 1, rd, er, lat, ex);
    total++; if (rd !== 32'h0000_0080) begin bad++; $display("FAIL lbu got=%h want=00000080", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er, ex; int lat, arv0, awv0;
    arv0 = ar_vld_cyc; awv0 = aw_vld_cyc;
    do_req(0, 32'h1000_0001, 32'h0, 2'd1, 0, rd, er, lat, ex);
    total++; if (er !== 1 || rd !== 32'h0 || lat !== 2) begin bad++; $display("FAIL mis_lh got err=%b rd=%h lat=%0d want 1/0/2", er, rd, lat); end
    total++; if (ar_vld_cyc - arv0 !== 0) begin bad++; $display("FAIL mis_no_arvalid got=%0d want=0", ar_vld_cyc - arv0); end
    total++; if (ex !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b want=0", ex); end
    do_req(0, 32'h1000_0000, 32'h0, 2'd3, 0, rd, er, lat, ex);
    total++; if (er !== 1 || ar_vld_cyc - arv0 !== 0) begin bad++; $display("FAIL mis_dword got err=%b ar=%0d want 1/0", er, ar_vld_cyc - arv0); end
    do_req(1, 32'h8000_0000, 32'h0102_0304, 2'd2, 0, rd, er, lat, ex);
    do_req(1, 32'h8000_0002, 32'hFFFF_FFFF, 2'd2, 0, rd, er, lat, ex);
    total++; if (er !== 1 || lat !== 2) begin bad++; $display("FAIL mis_sw got err=%b lat=%0d want 1/2", er, lat); end
    do_req(0, 32'h8000_0000, 32'h0, 2'd2, 0, rd, er, lat, ex);
    total++; if (rd !== 32'h0102_0304) begin bad++; $display("FAIL mis_spm_untouched got=%h want=01020304", rd); end
    total++; if (aw_vld_cyc - awv0 !== 0) begin bad++; $display("FAIL mis_no_awvalid got=%0d want=0", aw_vld_cyc - awv0); end
  endtask

  task automatic test_aw_delay();
    logic [31:0] rd; logic er, ex; int lat, awc, wc, bc;
    awc = aw_vld_cyc; wc = w_vld_cyc; bc = b_hs_cnt;
    cfg_aw_delay = 3; cfg_w_delay = 0;
    do_req(1, 32'h1000_0020, 32'h1122_3344, 2'd2, 0, rd, er, lat, ex);
    cfg_aw_delay = 0;
    total++; if (aw_vld_cyc - awc !== 4) begin bad++; $display("FAIL awvalid_cycles got=%0d want=4", aw_vld_cyc - awc); end
    total++; if (w_vld_cyc - wc !== 1) begin bad++; $display("FAIL wvalid_cycles got=%0d want=1", w_vld_cyc - wc); end
    total++; if (b_hs_cnt - bc !== 1) begin bad++; $display("FAIL b_handshakes got=%0d want=1", b_hs_cnt - bc); end
    total++; if (er !== 0) begin bad++; $display("FAIL awdelay_err got=%b want=0", er); end
    cfg_ar_delay = 2;
    do_req(0, 32'h1000_0022, 32'h0, 2'd1, 0, rd, er, lat, ex);
    cfg_ar_delay = 0;
    total++; if (rd !== 32'h0000_1122) begin bad++; $display("FAIL lh_bus got=%h want=00001122", rd); end
  endtask

  task automatic test_resp_err();
    logic [31:0] rd; logic er, ex; int lat;
    cfg_rresp = 2'b10;
    do_req(0, 32'h1000_0020, 32'h0, 2'd2, 0, rd, er, lat, ex);
    cfg_rresp = 2'b00;
    total++; if (er !== 1 || rd !== 32'h0) begin bad++; $display("FAIL rresp_err got err=%b rd=%h want 1/0", er, rd); end
    cfg_bresp = 2'b11;
    do_req(1, 32'h1000_0030, 32'h5, 2'd2, 0, rd, er, lat, ex);
    cfg_bresp = 2'b00;
    total++; if (er !== 1) begin bad++; $display("FAIL bresp_err got=%b want=1", er); end
    do_req(0, 32'h1000_0020, 32'h0, 2'd2, 0, rd, er, lat, ex);
    total++; if (er !== 0 || rd !== 32'h1122_3344) begin bad++; $display("FAIL rresp_ok got err=%b rd=%h want 0/11223344", er, rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, ex; int lat, r0; logic seen;
    cfg_r_hold = 1; seen = 0;
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_addr = 32'h1000_0020; req_size = 2'd2; req_unsigned = 0;
    @(posedge clk); #1; req_valid = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rready) seen = 1; else begin @(posedge clk); #1; end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL mid_reach_axr_d got=%b want=1", seen); end
    r0 = resp_cnt;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    total++; if ({req_ready, arvalid, rready, resp_valid} !== 4'b1000) begin bad++; $display("FAIL mid_rst got ready/ar/r/resp=%b want 1000", {req_ready, arvalid, rready, resp_valid}); end
    @(negedge clk); rst = 0; cfg_r_hold = 0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (resp_cnt - r0 !== 0) begin bad++; $display("FAIL mid_no_resp got=%0d want=0", resp_cnt - r0); end
    do_req(0, 32'h1000_0020, 32'h0, 2'd2, 0, rd, er, lat, ex);
    total++; if (er !== 0 || rd !== 32'h1122_3344) begin bad++; $display("FAIL mid_recover got err=%b rd=%h want 0/11223344", er, rd); end
  endtask

  initial begin
    test_reset();
    test_spm();
    test_bus_byte();
    test_misaligned();
    test_aw_delay();
    test_resp_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_axil_ctrl.md
LSU_AXIL_CTRL -- requirements
Module: lsu_axil_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): DATA_W, 32, data bus width, 32 or 64 only.
REQ-002 ADDR_W, 32, address width.
REQ-003 SPM_BASE, 32'h8000_0000, base address of the local scratchpad.
REQ-004 SPM_WORDS, 256, scratchpad depth in DATA_W words, a power of two.
REQ-005 The block SHALL have these ports (name, direction, width, meaning): clk, in, 1, the single clock; rst, in, 1, reset, synchronous and active-high.
REQ-006 Request ports: req_valid in 1; req_ready out 1; req_wen in 1; req_addr in ADDR_W; req_wdata in DATA_W, LSB-aligned store data; req_size in 2 (0 byte, 1 half, 2 word, 3 dword); req_unsigned in 1, zero-extend loads.
REQ-007 Response ports: resp_valid out 1; resp_rdata out DATA_W; resp_err out 1.
REQ-008 AXI4-Lite master ports: awaddr/awvalid/awready; wdata/wstrb(DATA_W/8)/wvalid/wready; bresp(2)/bvalid/bready; araddr/arvalid/arready; rdata/rresp(2)/rvalid/rready.

Function
REQ-009 A request SHALL be accepted on a cycle where req_valid and req_ready are both 1; req_ready SHALL be 1 only in state IDLE.
REQ-010 The FSM states SHALL be IDLE, SPM, AXW, AXB, AXR_A, AXR_D, RESP.
REQ-011 IDLE SHALL transition on acceptance as follows: misaligned -> RESP with err; in the SPM window -> SPM; write -> AXW; read -> AXR_A.
REQ-012 A request SHALL be misaligned when the address is not a multiple of 2^req_size; size 3 with DATA_W=32 SHALL also count as misaligned; a misaligned request SHALL touch neither the SPM nor the bus.
REQ-013 The SPM window SHALL be SPM_BASE <= addr < SPM_BASE + SPM_WORDS*DATA_W/8; the word index SHALL be (addr-SPM_BASE)>>log2(DATA_W/8).
REQ-014 SPM SHALL perform a synchronous read-modify-write with byte strobes in a single cycle, then go to RESP; total latency SHALL be 2 cycles from acceptance to resp_valid.
REQ-015 AXW SHALL drive awaddr=addr with the low offset bits cleared, and drive wdata as store data shifted left by offset*8, and drive wstrb as the size mask shifted by offset.
REQ-016 awvalid and wvalid SHALL be raised together, each SHALL drop independently on its own handshake, and the FSM SHALL enter AXB once both have completed, including handshakes in the same cycle.
REQ-017 bready SHALL be 1 only in AXB; on bvalid the FSM SHALL go to RESP with err=(bresp!=2'b00).
REQ-018 AXR_A SHALL hold arvalid with the aligned araddr until arready, then enter AXR_D; rready SHALL be 1 only in AXR_D; on rvalid the rdata and rresp SHALL be captured and the FSM SHALL go to RESP.
REQ-019 Load data SHALL be shifted right by offset*8, then sign-extended from bit 8*2^size-1, or zero-extended when req_unsigned=1.
REQ-020 RESP SHALL pulse resp_valid for exactly 1 cycle, then return to IDLE; resp_rdata SHALL be 0 for writes and for errors.
REQ-021 All AXI valid signals SHALL stay stable until their handshake; address and data SHALL NOT change while valid is high.
REQ-022 Request fields SHALL be registered at acceptance; later changes on req_* SHALL have no effect.

Reset
REQ-023 While rst=1 at a clock edge, the FSM SHALL enter IDLE and every valid, ready and response output SHALL be 0, except req_ready, which SHALL be 1 after reset.
REQ-024 The address and data outputs SHALL reset to 0; SPM contents SHALL NOT be reset.
REQ-025 A reset in mid-transaction SHALL abandon the transaction without any response; the slave is reset by the same rst.

Structure
REQ-026 A shared package lsu_pkg SHALL hold the FSM state enum, the size encodings, the AXI resp constants (OKAY=2'b00), and the strobe-mask and extend functions.
REQ-027 The scratchpad SHALL be the sub-module lsu_spm (parameters SPM_WORDS and DATA_W; one synchronous port with byte-write enables).

Verification
REQ-028 A 32-bit SW to 0x8000_0010 with 0xDEADBEEF followed by LW SHALL return 0xDEADBEEF with err=0, each response arriving 2 cycles after acceptance.
REQ-029 An SB of 0x80 to bus address 0x1000_0003 SHALL produce awaddr 0x1000_0000, wstrb 4'b1000, wdata 0x8000_0000; an LB back SHALL return 0xFFFF_FF80, and with req_unsigned=1 SHALL return 0x0000_0080.
REQ-030 An LH at 0x1000_0001 SHALL give resp_err=1 and resp_rdata=0 two cycles after acceptance, with no arvalid.
REQ-031 With awready delayed by 3 cycles and wready by 0, the bench SHALL see wvalid drop after 1 cycle, awvalid held for 4 cycles, then exactly one bready handshake.
REQ-032 A read answered with rresp=2'b10 SHALL give resp_err=1.
REQ-033 Asserting rst during AXR_D SHALL give req_ready=1 and arvalid=rready=0 on the next cycle, with no resp_valid.
